key_sequence_lock: RTL and testbench
====================================

# key_sequence_lock

Consumer end of the push-button signal interface. Receives the one-shot 3-bit key codes produced by the button front-end (K0..K3 = 3'b100..3'b111, NOP = 3'b000) and matches them against a fixed four-key passcode. The block drives an unlock strobe of programmable length, a failure pulse, an entry-progress count and a lockout flag after repeated failures. It sits between the button front-end and the lab's LED/7-segment display logic.

## Interface

- CODE, 8'b00_01_10_11, passcode as four 2-bit key indices; first key in [7:6], last in [1:0]
- TIMEOUT, 32'd50_000_000, idle cycles allowed between keys during entry before abort; must be ≥ 1
- HOLD, 32'd100_000_000, cycles unlock_o stays high; must be ≥ 1
- LOCKOUT_CYC, 32'd500_000_000, cycles locked_out_o stays high; must be ≥ 1
- MAX_FAIL, 2'd3, consecutive failed entries that trigger lockout; must be 1..3
- clk_i  input  1  system clock; all logic on rising edge
- rst_i  input  1  synchronous active-high reset
- signal_i  input  3  key code from the button front-end; one-cycle pulse per press
- unlock_o  output  1  high while the lock is open
- fail_o  output  1  one-cycle pulse on a completed wrong entry
- digits_o  output  3  keys entered in the current attempt, 0..4
- locked_out_o  output  1  high during lockout

## Operation

- Valid code: signal_i[2] == 1; the key index is signal_i[1:0]. Any value with signal_i[2] == 0 is NOP, whatever the low bits are.
- Internal state:
  - FSM states IDLE, ENTRY, OPEN, LOCKOUT.
  - 32-bit timer.
  - 2-bit fail counter.
  - mismatch flag.
  - 3-bit digit counter, which drives digits_o.
- IDLE:
  - On a valid code: digits = 1; mismatch = (key != CODE[7:6]); timer = 0; go to ENTRY.
- ENTRY (digits = n, 1..3):
  - On a valid code: compare the key with the CODE slice for position n. mismatch |= the difference. digits = n+1. Timer = 0.
  - If digits reaches 4 and the final mismatch is 0: go to OPEN; timer = 0; fail counter = 0.
  - If digits reaches 4 and the final mismatch is 1: pulse fail_o and increment the fail counter.
    - If the new fail count == MAX_FAIL: go to LOCKOUT with timer = 0.
    - Otherwise go to IDLE.
  - With no valid code: timer increments. When timer == TIMEOUT-1, go to IDLE with digits = 0. This abort changes neither fail_o nor the fail counter.
- OPEN:
  - unlock_o = 1.
  - All codes are ignored.
  - When timer == HOLD-1: go to IDLE; unlock_o = 0; digits = 0.
- LOCKOUT:
  - locked_out_o = 1.
  - All codes are ignored.
  - When timer == LOCKOUT_CYC-1: go to IDLE; fail counter = 0; digits = 0.
- A mismatch is evaluated only after all four keys are entered. An early wrong key does not abort the attempt.
- digits_o:
  - Holds at 4 while in OPEN.
  - Is 0 in IDLE and in LOCKOUT.
  - On a completed wrong entry, returns to 0 on the same edge that pulses fail_o.

## Timing

- Reset: on any rising edge with rst_i = 1, the block enters IDLE with unlock_o = 0, fail_o = 0, digits_o = 0, locked_out_o = 0, fail counter = 0, timer = 0 and mismatch = 0.
- Reset takes priority over all events, including reset asserted mid-entry, mid-OPEN or mid-LOCKOUT.
- All outputs are registered.
- A code sampled at edge t is reflected in digits_o, unlock_o, fail_o and locked_out_o after edge t. There is no extra latency.
- Durations:
  - unlock_o is high for exactly HOLD cycles.
  - locked_out_o is high for exactly LOCKOUT_CYC cycles.
  - fail_o is high for exactly 1 cycle.
- Timeout: the last accepted code at edge t with none afterwards gives the return to IDLE at edge t+TIMEOUT.
- A valid code arriving in the same cycle the timeout would fire is accepted, and the timer restarts.
- A code arriving on the cycle OPEN or LOCKOUT expires is ignored. The block reaches IDLE first and takes the next code only.
- Back-to-back valid codes on consecutive cycles are each accepted.

## Test plan

Bench parameters: CODE=8'b00_01_10_11, TIMEOUT=20, HOLD=10, LOCKOUT_CYC=30, MAX_FAIL=3.

1. Correct entry: send 100,101,110,111 with gaps of 5 cycles -> digits_o steps 1,2,3,4; unlock_o rises after the 4th code, stays high 10 cycles, then digits_o = 0.
2. Wrong entry: send 100,101,110,110 -> fail_o pulses once after the 4th code; digits_o = 0; unlock_o stays 0.
3. Lockout: three wrong entries -> locked_out_o high for 30 cycles after the third fail_o. A correct sequence sent during lockout gives no unlock_o. A correct sequence sent afterwards unlocks.
4. Timeout: send 100,101, then idle 20 cycles -> digits_o returns to 0 exactly 20 cycles after the second code; no fail_o. Repeat with the third code arriving at cycle 19 -> accepted, digits_o = 3.
5. NOP robustness: 3'b011 and 3'b001 interleaved within a correct sequence -> ignored; unlock occurs normally. Codes sent during OPEN -> digits_o stays 4 and the hold is not extended.
6. Reset mid-operation: assert rst_i for 1 cycle during ENTRY (digits = 2), during OPEN and during LOCKOUT -> every output is 0 on the next cycle and the fail counter is cleared. Verify the cleared fail counter by requiring three further fails before lockout.

Source files
------------

// File: rtl/key_sequence_lock.sv
// key_sequence_lock: matches one-shot key codes from the button front-end
// against a fixed four-key passcode. Drives a timed unlock strobe, a fail
// pulse, an entry-progress count and a timed lockout after repeated failures.
module key_sequence_lock #(
  parameter logic [7:0]  CODE        = 8'b00_01_10_11,
  parameter logic [31:0] TIMEOUT     = 32'd50_000_000,
  parameter logic [31:0] HOLD        = 32'd100_000_000,
  parameter logic [31:0] LOCKOUT_CYC = 32'd500_000_000,
  parameter logic [1:0]  MAX_FAIL    = 2'd3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] signal_i,
  output logic       unlock_o,
  output logic       fail_o,
  output logic [2:0] digits_o,
  output logic       locked_out_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ENTRY   = 2'd1,
    S_OPEN    = 2'd2,
    S_LOCKOUT = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] timer_q;
  logic [1:0]  fail_cnt_q;
  logic        mismatch_q;
  logic [2:0]  digits_q;
  logic        unlock_q;
  logic        fail_q;
  logic        locked_q;

  // Decoded key press and the comparison against the expected passcode slot.
  logic       key_valid;
  logic [1:0] key_idx;
  logic [1:0] key_ref;
  logic       mismatch_d;
  logic [1:0] fail_cnt_d;

  assign key_valid = signal_i[2];
  assign key_idx   = signal_i[1:0];

  // Select the passcode slot for the key about to be entered (digits_q keys so far).
  always_comb begin
    key_ref = CODE[7:6];
    case (digits_q[1:0])
      2'd1:    key_ref = CODE[5:4];
      2'd2:    key_ref = CODE[3:2];
      2'd3:    key_ref = CODE[1:0];
      default: key_ref = CODE[7:6];
    endcase
  end

  // Mismatch is accumulated and only judged once all four keys are in.
  assign mismatch_d = mismatch_q | (key_idx != key_ref);
  // MAX_FAIL is at most 3, so the 2-bit increment is compared before it could wrap.
  assign fail_cnt_d = fail_cnt_q + 2'd1;

  // Lock controller: state, timer, counters and all registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      timer_q    <= 32'd0;
      fail_cnt_q <= 2'd0;
      mismatch_q <= 1'b0;
      digits_q   <= 3'd0;
      unlock_q   <= 1'b0;
      fail_q     <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      fail_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (key_valid) begin
            digits_q   <= 3'd1;
            mismatch_q <= (key_idx != CODE[7:6]);
            timer_q    <= 32'd0;
            state_q    <= S_ENTRY;
          end
        end

        S_ENTRY: begin
          if (key_valid) begin
            // A key arriving on the timeout cycle wins and restarts the timer.
            timer_q <= 32'd0;
            if (digits_q == 3'd3) begin
              mismatch_q <= 1'b0;
              if (!mismatch_d) begin
                state_q    <= S_OPEN;
                unlock_q   <= 1'b1;
                digits_q   <= 3'd4;
                fail_cnt_q <= 2'd0;
              end else begin
                fail_q     <= 1'b1;
                digits_q   <= 3'd0;
                fail_cnt_q <= fail_cnt_d;
                if (fail_cnt_d == MAX_FAIL) begin
                  state_q  <= S_LOCKOUT;
                  locked_q <= 1'b1;
                end else begin
                  state_q <= S_IDLE;
                end
              end
            end else begin
              digits_q   <= digits_q + 3'd1;
              mismatch_q <= mismatch_d;
            end
          end else if (timer_q == TIMEOUT - 32'd1) begin
            // Abandoned attempt: silent abort, fail history untouched.
            state_q    <= S_IDLE;
            digits_q   <= 3'd0;
            mismatch_q <= 1'b0;
            timer_q    <= 32'd0;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end

        S_OPEN: begin
          // Keys are ignored while open, including on the expiry cycle.
          if (timer_q == HOLD - 32'd1) begin
            state_q  <= S_IDLE;
            unlock_q <= 1'b0;
            digits_q <= 3'd0;
            timer_q  <= 32'd0;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end

        S_LOCKOUT: begin
          // Keys are ignored while locked out, including on the expiry cycle.
          if (timer_q == LOCKOUT_CYC - 32'd1) begin
            state_q    <= S_IDLE;
            locked_q   <= 1'b0;
            fail_cnt_q <= 2'd0;
            digits_q   <= 3'd0;
            timer_q    <= 32'd0;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign unlock_o     = unlock_q;
  assign fail_o       = fail_q;
  assign digits_o     = digits_q;
  assign locked_out_o = locked_q;

endmodule

// File: tb/tb_key_sequence_lock.sv
// Directed bench for key_sequence_lock with small timing parameters.
module tb_key_sequence_lock;

  logic       clk;
  logic       rst;
  logic [2:0] signal;
  logic       unlock;
  logic       fail;
  logic [2:0] digits;
  logic       locked;

  int tests_run    = 0;
  int tests_failed = 0;

  key_sequence_lock #(
    .CODE        (8'b00_01_10_11),
    .TIMEOUT     (32'd20),
    .HOLD        (32'd10),
    .LOCKOUT_CYC (32'd30),
    .MAX_FAIL    (2'd3)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .signal_i     (signal),
    .unlock_o     (unlock),
    .fail_o       (fail),
    .digits_o     (digits),
    .locked_out_o (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge: the code is sampled on the next posedge, and the
  // task returns at the following negedge where outputs reflect it.
  task automatic send(input logic [2:0] c);
    signal = c;
    @(negedge clk);
    signal = 3'b000;
    $display("[TB] t=%0t key=%b digits=%0d unlock=%b fail=%b locked=%b",
             $time, c, digits, unlock, fail, locked);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Four back-to-back codes, first in [11:9].
  task automatic enter(input logic [11:0] keys);
    send(keys[11:9]);
    send(keys[8:6]);
    send(keys[5:3]);
    send(keys[2:0]);
  endtask

  localparam logic [11:0] GOOD = {3'b100, 3'b101, 3'b110, 3'b111};
  localparam logic [11:0] BAD  = {3'b100, 3'b101, 3'b110, 3'b110};

  task automatic test_reset();
    rst = 1'b1;
    signal = 3'b000;
    idle(2);
    tests_run++;
    if ({unlock, fail, digits, locked} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_in: outs=%b exp=000000", {unlock, fail, digits, locked});
    end
    rst = 1'b0;
    idle(3);
    tests_run++;
    if ({unlock, fail, digits, locked} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_after: outs=%b exp=000000", {unlock, fail, digits, locked});
    end
  endtask

  task automatic test_correct_entry();
    int cnt;
    logic [2:0] keys [4] = '{3'b100, 3'b101, 3'b110, 3'b111};
    for (int i = 0; i < 4; i++) begin
      if (i > 0) idle(4);
      send(keys[i]);
      tests_run++;
      if (digits !== 3'(i + 1)) begin
        tests_failed++;
        $display("FAIL correct_digits%0d: got=%0d exp=%0d", i, digits, i + 1);
      end
    end
    tests_run++;
    if (unlock !== 1'b1) begin
      tests_failed++;
      $display("FAIL correct_unlock: got=%b exp=1", unlock);
    end
    cnt = 0;
    while (unlock === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    tests_run++;
    if (cnt != 10) begin
      tests_failed++;
      $display("FAIL correct_hold_len: got=%0d exp=10", cnt);
    end
    tests_run++;
    if (digits !== 3'd0) begin
      tests_failed++;
      $display("FAIL correct_digits_after: got=%0d exp=0", digits);
    end
  endtask

  task automatic test_wrong_entry();
    send(3'b100);
    send(3'b101);
    send(3'b110);
    tests_run++;
    if (digits !== 3'd3) begin
      tests_failed++;
      $display("FAIL wrong_d3: got=%0d exp=3", digits);
    end
    send(3'b110);
    tests_run++;
    if ({fail, digits, unlock, locked} !== {1'b1, 3'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL wrong_pulse: fail/digits/unlock/locked=%b exp=100000",
               {fail, digits, unlock, locked});
    end
    idle(1);
    tests_run++;
    if (fail !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrong_pulse_len: got=%b exp=0", fail);
    end
    // Wrong first key does not abort: all four keys still counted.
    send(3'b111);
    tests_run++;
    if (digits !== 3'd1) begin
      tests_failed++;
      $display("FAIL early_wrong_d1: got=%0d exp=1", digits);
    end
    send(3'b101);
    send(3'b110);
    send(3'b111);
    tests_run++;
    if ({fail, digits, unlock} !== {1'b1, 3'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL early_wrong_fail: fail/digits/unlock=%b exp=10000", {fail, digits, unlock});
    end
  endtask

  task automatic test_lockout();
    pulse_reset();
    enter(BAD);
    enter(BAD);
    tests_run++;
    if ({fail, locked} !== 2'b10) begin
      tests_failed++;
      $display("FAIL lock_second: fail/locked=%b exp=10", {fail, locked});
    end
    enter(BAD);
    tests_run++;
    if ({fail, locked, digits} !== {1'b1, 1'b1, 3'd0}) begin
      tests_failed++;
      $display("FAIL lock_enter: fail/locked/digits=%b exp=11000", {fail, locked, digits});
    end
    // Correct sequence during lockout is ignored (edges t+1..t+4).
    enter(GOOD);
    tests_run++;
    if ({unlock, locked, digits} !== {1'b0, 1'b1, 3'd0}) begin
      tests_failed++;
      $display("FAIL lock_ignore: unlock/locked/digits=%b exp=01000", {unlock, locked, digits});
    end
    idle(25);
    tests_run++;
    if (locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL lock_last_cycle: got=%b exp=1", locked);
    end
    // Code on the expiry edge is dropped.
    send(3'b100);
    tests_run++;
    if ({locked, digits} !== {1'b0, 3'd0}) begin
      tests_failed++;
      $display("FAIL lock_expire: locked/digits=%b exp=0000", {locked, digits});
    end
    enter(GOOD);
    tests_run++;
    if ({unlock, digits} !== {1'b1, 3'd4}) begin
      tests_failed++;
      $display("FAIL lock_after_unlock: unlock/digits=%b exp=1100", {unlock, digits});
    end
  endtask

  task automatic test_timeout();
    pulse_reset();
    send(3'b100);
    send(3'b101);
    idle(19);
    tests_run++;
    if (digits !== 3'd2) begin
      tests_failed++;
      $display("FAIL tmo_before: got=%0d exp=2", digits);
    end
    idle(1);
    tests_run++;
    if ({digits, fail} !== {3'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL tmo_fire: digits/fail=%b exp=0000", {digits, fail});
    end
    // Third code at offset 19 is accepted and restarts the timer.
    send(3'b100);
    send(3'b101);
    idle(18);
    send(3'b110);
    tests_run++;
    if (digits !== 3'd3) begin
      tests_failed++;
      $display("FAIL tmo_c19: got=%0d exp=3", digits);
    end
    idle(19);
    tests_run++;
    if (digits !== 3'd3) begin
      tests_failed++;
      $display("FAIL tmo_restart: got=%0d exp=3", digits);
    end
    idle(1);
    tests_run++;
    if (digits !== 3'd0) begin
      tests_failed++;
      $display("FAIL tmo_restart_fire: got=%0d exp=0", digits);
    end
    // Third code exactly on the timeout edge (offset 20) still wins.
    send(3'b100);
    send(3'b101);
    idle(19);
    send(3'b110);
    tests_run++;
    if (digits !== 3'd3) begin
      tests_failed++;
      $display("FAIL tmo_c20: got=%0d exp=3", digits);
    end
    send(3'b111);
    tests_run++;
    if (unlock !== 1'b1) begin
      tests_failed++;
      $display("FAIL tmo_c20_unlock: got=%b exp=1", unlock);
    end
  endtask

  task automatic test_nop();
    logic [2:0] seq [7] = '{3'b100, 3'b011, 3'b101, 3'b001, 3'b110, 3'b011, 3'b111};
    logic [2:0] exp [7] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4};
    pulse_reset();
    for (int i = 0; i < 7; i++) begin
      send(seq[i]);
      tests_run++;
      if (digits !== exp[i]) begin
        tests_failed++;
        $display("FAIL nop_step%0d: got=%0d exp=%0d", i, digits, exp[i]);
      end
    end
    tests_run++;
    if (unlock !== 1'b1) begin
      tests_failed++;
      $display("FAIL nop_unlock: got=%b exp=1", unlock);
    end
    // Codes during OPEN (edges t+1, t+2) are ignored.
    send(3'b101);
    send(3'b100);
    tests_run++;
    if ({unlock, digits} !== {1'b1, 3'd4}) begin
      tests_failed++;
      $display("FAIL open_ignore: unlock/digits=%b exp=1100", {unlock, digits});
    end
    idle(7);
    tests_run++;
    if ({unlock, digits} !== {1'b1, 3'd4}) begin
      tests_failed++;
      $display("FAIL open_last: unlock/digits=%b exp=1100", {unlock, digits});
    end
    // Code on the expiry edge is dropped and the hold is not extended.
    send(3'b100);
    tests_run++;
    if ({unlock, digits} !== {1'b0, 3'd0}) begin
      tests_failed++;
      $display("FAIL open_expire: unlock/digits=%b exp=0000", {unlock, digits});
    end
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    send(3'b100);
    tests_run++;
    if (digits !== 3'd1) begin
      tests_failed++;
      $display("FAIL b2b_d1: got=%0d exp=1", digits);
    end
    send(3'b101);
    send(3'b110);
    tests_run++;
    if (digits !== 3'd3) begin
      tests_failed++;
      $display("FAIL b2b_d3: got=%0d exp=3", digits);
    end
    send(3'b111);
    tests_run++;
    if ({unlock, digits} !== {1'b1, 3'd4}) begin
      tests_failed++;
      $display("FAIL b2b_open: unlock/digits=%b exp=1100", {unlock, digits});
    end
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    enter(BAD);
    enter(BAD);
    send(3'b100);
    send(3'b101);
    pulse_reset();
    tests_run++;
    if ({unlock, fail, digits, locked} !== 6'b0) begin
      tests_failed++;
      $display("FAIL rst_entry: outs=%b exp=000000", {unlock, fail, digits, locked});
    end
    // Fail counter cleared: two more fails do not lock, the third does.
    enter(BAD);
    enter(BAD);
    tests_run++;
    if (locked !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_cnt_cleared: locked=%b exp=0", locked);
    end
    enter(BAD);
    tests_run++;
    if (locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_third_lock: locked=%b exp=1", locked);
    end
    idle(3);
    pulse_reset();
    tests_run++;
    if ({unlock, fail, digits, locked} !== 6'b0) begin
      tests_failed++;
      $display("FAIL rst_lockout: outs=%b exp=000000", {unlock, fail, digits, locked});
    end
    enter(GOOD);
    tests_run++;
    if (unlock !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_reopen: unlock=%b exp=1", unlock);
    end
    idle(2);
    pulse_reset();
    tests_run++;
    if ({unlock, fail, digits, locked} !== 6'b0) begin
      tests_failed++;
      $display("FAIL rst_open: outs=%b exp=000000", {unlock, fail, digits, locked});
    end
    idle(1);
    tests_run++;
    if ({unlock, digits} !== 4'b0) begin
      tests_failed++;
      $display("FAIL rst_open_stay: unlock/digits=%b exp=0000", {unlock, digits});
    end
  endtask

  initial begin
    rst = 1'b1;
    signal = 3'b000;
    test_reset();
    test_correct_entry();
    test_wrong_entry();
    test_lockout();
    test_timeout();
    test_nop();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

endmodule
